// File: rtl/integration_pkg.sv
// Shared types for the AHB arbiter slice: transfer encodings, arbiter FSM states
// and the upper bound on the number of masters.
package integration_pkg;

    localparam int MAX_MASTERS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [1:0] {
        DEFAULT = 2'd0,
        GRANTED = 2'd1,
        LOCKED  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ahb_prio_encoder.sv
// Masked fixed-priority pick: the lowest-index request not excluded by mask wins.
module ahb_prio_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        // Scan downwards so the lowest eligible index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && !mask[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Fixed-priority AHB arbiter with default master, locked-transfer hold and a
// hold limit that lets a waiting requester through after MAX_HOLD cycles.
module ahb_bus_arbiter
    import integration_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = NUM_MASTERS - 1,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam int IDX_W = (NUM_MASTERS <= 2) ? 1 : $clog2(NUM_MASTERS);
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]       HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [CNT_W-1:0]       hold_cnt;
    logic [IDX_W-1:0]       owner;

    logic [NUM_MASTERS-1:0] win_oh, other_oh, nxt_oh;
    logic [IDX_W-1:0]       win_idx, other_idx_unused;
    logic                   win_vld, other_vld, preempt;
    arb_state_t             nxt_st;

    ahb_prio_encoder #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_all (
        .req    (hbusreq),
        .mask   ({NUM_MASTERS{1'b0}}),
        .onehot (win_oh),
        .idx    (win_idx),
        .vld    (win_vld)
    );

    ahb_prio_encoder #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_pick_other (
        .req    (hbusreq),
        .mask   (grant_q),
        .onehot (other_oh),
        .idx    (other_idx_unused),
        .vld    (other_vld)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner = IDX_W'(i);
        end
    end

    // Re-arbitration result; whether it is applied depends on FSM state and hready.
    always_comb begin
        preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && other_vld;
        nxt_oh  = DEF_OH;
        nxt_st  = DEFAULT;
        if (preempt) begin
            nxt_oh = other_oh;
            nxt_st = GRANTED;
        end else if (win_vld) begin
            nxt_oh = win_oh;
            nxt_st = GRANTED;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset) begin
            grant_q   <= DEF_OH;
            hmaster   <= 4'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
            state     <= DEFAULT;
            hold_cnt  <= '0;
        end else if (hready) begin
            hmaster   <= 4'(owner);
            hmastlock <= hlock[owner];
            if (state == GRANTED && hlock[owner]) begin
                state    <= LOCKED;
                hold_cnt <= '0;
            end else if (state != LOCKED || (!hlock[owner] && htrans_t'(htrans) != BUSY)) begin
                grant_q <= nxt_oh;
                state   <= nxt_st;
                if (nxt_oh != grant_q) begin
                    hold_cnt <= '0;
                end else if (other_vld && win_idx == owner && hold_cnt != HOLD_LIM) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    assign hgrant = grant_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, hold limit 4) with hand-computed
// expectations and a continuous one-hot grant check.
module tb_ahb_bus_arbiter;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;
    logic [1:0] htrans;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (3),
        .MAX_HOLD       (4)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .hready    (hready),
        .htrans    (htrans),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    always @(negedge hclk) begin
        if (!done) chk("onehot", 32'($onehot(hgrant)), 32'd1);
    end

    initial begin
        hreset  = 1'b0;
        hbusreq = 4'b1111;
        hlock   = 4'b0000;
        hready  = 1'b1;
        htrans  = 2'd0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 32'(hgrant), 32'h8);
            chk("rst_hmaster", 32'(hmaster), 32'd3);
            chk("rst_lock", 32'(hmastlock), 32'd0);
        end
        hreset = 1'b1;
        tick();
        chk("rel_grant", 32'(hgrant), 32'h1);

        hbusreq = 4'b0110;
        tick();
        chk("prio_grant", 32'(hgrant), 32'h2);
        tick();
        chk("prio_hmaster", 32'(hmaster), 32'd1);
        chk("prio_hold", 32'(hgrant), 32'h2);
        hbusreq = 4'b0100;
        tick();
        chk("drop_grant", 32'(hgrant), 32'h4);

        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_hmaster", 32'(hmaster), 32'd1);
        end
        hready = 1'b1;
        tick();
        chk("ws_hmaster_rel", 32'(hmaster), 32'd2);
        chk("ws_grant", 32'(hgrant), 32'h4);

        hlock = 4'b0100;
        tick();
        chk("lock_grant", 32'(hgrant), 32'h4);
        chk("lock_mastlock", 32'(hmastlock), 32'd1);
        hbusreq = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("locked_grant", 32'(hgrant), 32'h4);
            chk("locked_mastlock", 32'(hmastlock), 32'd1);
        end
        hlock  = 4'b0000;
        htrans = 2'd1;
        tick();
        chk("busy_hold", 32'(hgrant), 32'h4);
        htrans = 2'd2;
        tick();
        chk("unlock_grant", 32'(hgrant), 32'h1);
        chk("unlock_hmaster", 32'(hmaster), 32'd2);

        hbusreq = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_count", 32'(hgrant), 32'h1);
        end
        tick();
        chk("starve_grant", 32'(hgrant), 32'h2);
        tick();
        chk("starve_back", 32'(hgrant), 32'h1);
        chk("starve_hmaster", 32'(hmaster), 32'd1);

        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_count2", 32'(hgrant), 32'h1);
        end
        hlock = 4'b0001;
        tick();
        chk("lock_over_hold", 32'(hgrant), 32'h1);
        tick();
        chk("lock_over_hold2", 32'(hgrant), 32'h1);
        chk("lock_over_mastlock", 32'(hmastlock), 32'd1);
        hlock = 4'b0000;
        tick();
        chk("relock_exit", 32'(hgrant), 32'h1);

        hbusreq = 4'b0000;
        tick();
        tick();
        chk("idle_grant", 32'(hgrant), 32'h8);
        chk("idle_hmaster", 32'(hmaster), 32'd3);
        hbusreq = 4'b1000;
        hlock   = 4'b0001;
        tick();
        chk("def_req_grant", 32'(hgrant), 32'h8);
        chk("foreign_lock", 32'(hmastlock), 32'd0);
        hbusreq = 4'b0001;
        hlock   = 4'b0000;
        tick();
        chk("req0_grant", 32'(hgrant), 32'h1);

        hready = 1'b0;
        hreset = 1'b0;
        tick();
        chk("midrst_grant", 32'(hgrant), 32'h8);
        chk("midrst_hmaster", 32'(hmaster), 32'd3);
        chk("midrst_lock", 32'(hmastlock), 32'd0);
        hreset  = 1'b1;
        hready  = 1'b1;
        hbusreq = 4'b0000;
        tick();
        chk("post_rst_idle", 32'(hgrant), 32'h8);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
